// File: rtl/iic_responder_pkg.sv
// rtl/iic_responder_pkg.sv - shared types and constants for the I2C register responder
package iic_responder_pkg;

   typedef enum logic [3:0] {
      IDLE,
      DEV_ADDR,
      ACK_ADDR,
      REG_ADDR,
      ACK_REG,
      WRITE_DATA,
      ACK_DATA,
      READ_DATA,
      READ_ACK,
      WAIT_STOP
   } iic_state_t;

   localparam logic IIC_ACK  = 1'b0;
   localparam logic IIC_NACK = 1'b1;

endpackage

// File: rtl/iic_line_filter.sv
// rtl/iic_line_filter.sv - pad synchronizer, glitch filter and edge flags for one I2C line
module iic_line_filter #(
   parameter int FILTER_LEN = 3
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Idle bus is high, so everything resets to 1 to avoid a phantom edge after reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         cnt   <= '0;
         level <= 1'b1;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= pad;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/iic_responder.sv
// rtl/iic_responder.sv - oversampled I2C target with an 8-bit-addressed register bank
module iic_responder
   import iic_responder_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = 7'h76,
   parameter int         NUM_REGS    = 256,
   parameter int         FILTER_LEN  = 3
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data,
   output logic       busy
);

   localparam int PW = $clog2(NUM_REGS);

   logic          scl_f, scl_rise, scl_fall;
   logic          sda_f, sda_rise, sda_fall;
   logic          start_ev, stop_ev;
   iic_state_t    state, state_n;
   logic [7:0]    shift, shift_n, rx_byte;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [PW-1:0] ptr, ptr_n;
   logic          sda_oe_n, busy_n, wr_en;
   logic [7:0]    regs [NUM_REGS];

   iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .Clk(Clk), .Reset_n(Reset_n), .pad(scl_in), .level(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .Clk(Clk), .Reset_n(Reset_n), .pad(sda_in), .level(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   assign start_ev = sda_fall & scl_f;
   assign stop_ev  = sda_rise & scl_f;
   assign rx_byte  = {shift[6:0], sda_f};
   assign dbg_data = regs[dbg_addr[PW-1:0]];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         ptr       <= '0;
         sda_oe    <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state     <= state_n;
         shift     <= shift_n;
         bit_cnt   <= bit_cnt_n;
         ptr       <= ptr_n;
         sda_oe    <= sda_oe_n;
         busy      <= busy_n;
         wr_strobe <= wr_en;
         if (wr_en) begin
            regs[ptr] <= rx_byte;
            wr_addr   <= 8'(ptr);
            wr_data   <= rx_byte;
         end
      end
   end

   // ACK states: the first SCL fall pulls SDA low, the second (end of 9th clock) releases it.
   always_comb begin
      state_n   = state;
      shift_n   = shift;
      bit_cnt_n = bit_cnt;
      ptr_n     = ptr;
      sda_oe_n  = sda_oe;
      busy_n    = busy;
      wr_en     = 1'b0;
      if (stop_ev) begin
         state_n  = IDLE;
         sda_oe_n = 1'b0;
         busy_n   = 1'b0;
      end else if (start_ev) begin
         state_n   = DEV_ADDR;
         sda_oe_n  = 1'b0;
         bit_cnt_n = '0;
      end else begin
         case (state)
            DEV_ADDR: if (scl_rise) begin
               shift_n   = rx_byte;
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  if (rx_byte[7:1] == DEVICE_ADDR) begin
                     state_n = ACK_ADDR;
                     busy_n  = 1'b1;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
            ACK_ADDR: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else begin
                  bit_cnt_n = '0;
                  if (shift[0]) begin
                     state_n  = READ_DATA;
                     shift_n  = regs[ptr];
                     sda_oe_n = ~regs[ptr][7];
                  end else begin
                     state_n  = REG_ADDR;
                     sda_oe_n = 1'b0;
                  end
               end
            end
            REG_ADDR: if (scl_rise) begin
               shift_n   = rx_byte;
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  ptr_n   = rx_byte[PW-1:0];
                  state_n = ACK_REG;
               end
            end
            ACK_REG: if (scl_fall) begin
               sda_oe_n = ~sda_oe;
               if (sda_oe) begin
                  state_n   = WRITE_DATA;
                  bit_cnt_n = '0;
               end
            end
            WRITE_DATA: if (scl_rise) begin
               shift_n   = rx_byte;
               bit_cnt_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'd7) begin
                  wr_en   = 1'b1;
                  state_n = ACK_DATA;
               end
            end
            ACK_DATA: if (scl_fall) begin
               sda_oe_n = ~sda_oe;
               if (sda_oe) begin
                  state_n   = WRITE_DATA;
                  bit_cnt_n = '0;
                  ptr_n     = ptr + 1'b1;
               end
            end
            READ_DATA: begin
               if (scl_rise) bit_cnt_n = bit_cnt + 4'd1;
               if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     state_n  = READ_ACK;
                     sda_oe_n = 1'b0;
                  end else begin
                     shift_n  = {shift[6:0], 1'b0};
                     sda_oe_n = ~shift[6];
                  end
               end
            end
            // bit_cnt==0 marks that the master has ACKed and the next byte starts at the coming fall.
            READ_ACK: begin
               if (scl_rise) begin
                  if (sda_f == IIC_NACK) begin
                     state_n = WAIT_STOP;
                  end else begin
                     ptr_n     = ptr + 1'b1;
                     bit_cnt_n = '0;
                  end
               end else if (scl_fall && bit_cnt == 4'd0) begin
                  state_n  = READ_DATA;
                  shift_n  = regs[ptr];
                  sda_oe_n = ~regs[ptr][7];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
